// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the instruction-fetch and data ports, with strict data priority.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e              state_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                grant_i_s;
    logic                grant_d_s;
    logic                force_i_s;
    logic                done_i_s;
    logic                done_d_s;
    logic                other_req_s;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_q;

    assign force_i_s = instr_req_i && (starve_q == CNT_W'(STARVE_LIMIT));

    // Counts data grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starve_q <= {CNT_W{1'b0}};
        end else if (grant_i_s) begin
            starve_q <= {CNT_W{1'b0}};
        end else if (grant_d_s && instr_req_i && (starve_q < CNT_W'(STARVE_LIMIT))) begin
            starve_q <= starve_q + CNT_W'(1);
        end else begin
            starve_q <= starve_q;
        end
    end
`else
    // Guard disabled: a fetch is never forced ahead of data traffic.
    assign force_i_s = (STARVE_LIMIT < 0);
`endif

    // Grant decision: only in IDLE, data first unless the guard forces the fetch.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_q == IDLE) begin
            grant_d_s = data_req_i & ~force_i_s;
            grant_i_s = instr_req_i & (~data_req_i | force_i_s);
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Transaction sequencer; memory-side outputs are held in registers for the whole access.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d_s) begin
                        state_q   <= BUSY_D;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= data_we_i;
                        addr_q    <= data_addr_i;
                        wdata_q   <= data_wdata_i;
                    end else if (grant_i_s) begin
                        state_q   <= BUSY_I;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        addr_q    <= instr_addr_i;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ready_i) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end else begin
                        state_q   <= state_q;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done_i_s = (state_q == BUSY_I) & mem_ready_i;
    assign done_d_s = (state_q == BUSY_D) & mem_ready_i;

    // The completing access only releases the core if the other port has nothing waiting.
    always_comb begin
        case (state_q)
            BUSY_I:  other_req_s = data_req_i;
            BUSY_D:  other_req_s = instr_req_i;
            default: other_req_s = 1'b0;
        endcase
    end

    assign instr_gnt_o    = grant_i_s;
    assign data_gnt_o     = grant_d_s;
    assign instr_rvalid_o = done_i_s;
    assign data_rvalid_o  = done_d_s;
    assign instr_rdata_o  = done_i_s ? mem_rdata_i : {DATA_W{1'b0}};
    assign data_rdata_o   = (done_d_s && !mem_we_q) ? mem_rdata_i : {DATA_W{1'b0}};
    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign stall_o        = (instr_req_i | data_req_i | mem_req_q) &
                            ~((done_i_s | done_d_s) & ~other_req_s);

endmodule
